// File: rtl/operand_buffer.sv
// Double-banked operand store feeding a 2x2 systolic array with registered operands.
// Optional macro OPERAND_TRANSPOSE_EN adds a transpose input that remaps the b-side operands.
module operand_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [2:0]        mem_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        a0_sel,
    input  logic [1:0]        a1_sel,
    input  logic [1:0]        b0_sel,
    input  logic [1:0]        b1_sel,
`ifdef OPERAND_TRANSPOSE_EN
    input  logic              transpose,
`endif
    output logic [DATA_W-1:0] a0,
    output logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] b0,
    output logic [DATA_W-1:0] b1,
    output logic              bank_valid,
    output logic              load_err
);

    logic [DATA_W-1:0] r_bank [2][8];
    logic              r_wrPtr;
    logic [7:0]        r_writeMask;

    logic              w_rdPtr;
    logic              w_commit;
    logic              w_complete;
    logic              w_transpose;
    logic [DATA_W-1:0] w_a0;
    logic [DATA_W-1:0] w_a1;
    logic [DATA_W-1:0] w_b0;
    logic [DATA_W-1:0] w_b1;

`ifdef OPERAND_TRANSPOSE_EN
    assign w_transpose = transpose;
`else
    assign w_transpose = 1'b0;
`endif

    assign w_rdPtr    = ~r_wrPtr;
    assign w_commit   = load_en && (mem_addr == 3'd7);
    // Address 7 counts as written by the commit write itself.
    assign w_complete = &(r_writeMask | 8'h80);

    function automatic logic [DATA_W-1:0] pick(input logic [1:0] sel,
                                               input logic [DATA_W-1:0] opt0,
                                               input logic [DATA_W-1:0] opt1);
        case (sel)
            2'd0:    return opt0;
            2'd1:    return opt1;
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 8; i++) begin
                    r_bank[b][i] <= '0;
                end
            end
            r_writeMask <= '0;
            r_wrPtr     <= 1'b0;
            bank_valid  <= 1'b0;
            load_err    <= 1'b0;
        end else if (load_en) begin
            r_bank[r_wrPtr][mem_addr] <= data_in;
            if (w_commit) begin
                r_writeMask <= '0;
                if (w_complete) begin
                    r_wrPtr    <= ~r_wrPtr;
                    bank_valid <= 1'b1;
                end else begin
                    load_err   <= 1'b1;
                end
            end else begin
                r_writeMask <= r_writeMask | (8'b1 << mem_addr);
            end
        end
    end

    // Read bank bytes: 0-3 weights w0..w3, 4-7 inputs x0..x3.
    always_comb begin
        w_a0 = '0;
        w_a1 = '0;
        w_b0 = '0;
        w_b1 = '0;
        if (bank_valid) begin
            w_a0 = pick(a0_sel, r_bank[w_rdPtr][0], r_bank[w_rdPtr][1]);
            w_a1 = pick(a1_sel, r_bank[w_rdPtr][2], r_bank[w_rdPtr][3]);
            if (w_transpose) begin
                w_b0 = pick(b0_sel, r_bank[w_rdPtr][4], r_bank[w_rdPtr][5]);
                w_b1 = pick(b1_sel, r_bank[w_rdPtr][6], r_bank[w_rdPtr][7]);
            end else begin
                w_b0 = pick(b0_sel, r_bank[w_rdPtr][4], r_bank[w_rdPtr][6]);
                w_b1 = pick(b1_sel, r_bank[w_rdPtr][5], r_bank[w_rdPtr][7]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a0 <= '0;
            a1 <= '0;
            b0 <= '0;
            b1 <= '0;
        end else begin
            a0 <= w_a0;
            a1 <= w_a1;
            b0 <= w_b0;
            b1 <= w_b1;
        end
    end

endmodule

// File: tb/tb_operand_buffer.sv
// Scoreboard bench for operand_buffer: directed vectors push expectations, a monitor pops and compares.
// Define OPERAND_TRANSPOSE_EN to also exercise the transpose port.
module tb_operand_buffer;

    typedef struct packed {
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       valid;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       loadEn = 1'b0;
    logic [2:0] memAddr = '0;
    logic [7:0] dataIn = '0;
    logic [1:0] a0Sel = '0;
    logic [1:0] a1Sel = '0;
    logic [1:0] b0Sel = '0;
    logic [1:0] b1Sel = '0;
    logic       tr = 1'b0;
    logic [7:0] a0, a1, b0, b1;
    logic       bankValid, loadErr;

    logic       tbCheck = 1'b0;
    logic       chkPending = 1'b0;
    exp_t       expQ[$];
    int         nTests = 0;
    int         nFail = 0;

    operand_buffer #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .load_en(loadEn), .mem_addr(memAddr), .data_in(dataIn),
        .a0_sel(a0Sel), .a1_sel(a1Sel), .b0_sel(b0Sel), .b1_sel(b1Sel),
`ifdef OPERAND_TRANSPOSE_EN
        .transpose(tr),
`endif
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .bank_valid(bankValid), .load_err(loadErr)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] ea0, input logic [7:0] ea1,
                                input logic [7:0] eb0, input logic [7:0] eb1,
                                input logic ev, input logic ee);
        exp_t e;
        e.a0 = ea0; e.a1 = ea1; e.b0 = eb0; e.b1 = eb1; e.valid = ev; e.err = ee;
        return e;
    endfunction

    // Drive one cycle of inputs at the falling edge; the outputs after the next rising edge are checked.
    task automatic applyStimulus(input logic iRst, input logic iLoad, input logic [2:0] iAddr,
                                 input logic [7:0] iData, input logic [7:0] iSels,
                                 input logic iTr, input logic iChk, input exp_t iExp);
        @(negedge clk);
        rst = iRst;
        loadEn = iLoad;
        memAddr = iAddr;
        dataIn = iData;
        {a0Sel, a1Sel, b0Sel, b1Sel} = iSels;
        tr = iTr;
        tbCheck = iChk;
        if (iChk) expQ.push_back(iExp);
    endtask

    task automatic checkOutput();
        exp_t e;
        exp_t act;
        act = mk(a0, a1, b0, b1, bankValid, loadErr);
        nTests++;
        if (expQ.size() == 0) begin
            nFail++;
            $display("[TB] FAIL scoreboard_empty: got %h, no expected entry", act);
        end else begin
            e = expQ.pop_front();
            if (act !== e) begin
                nFail++;
                $display("[TB] FAIL operands @%0t: got a0=%h a1=%h b0=%h b1=%h v=%b e=%b, want a0=%h a1=%h b0=%h b1=%h v=%b e=%b",
                         $time, act.a0, act.a1, act.b0, act.b1, act.valid, act.err,
                         e.a0, e.a1, e.b0, e.b1, e.valid, e.err);
            end
        end
    endtask

    always @(posedge clk) chkPending <= tbCheck;

    always @(negedge clk) begin
        if (chkPending) checkOutput();
    end

    initial begin
        // Reset and idle after reset
        applyStimulus(1, 0, 0, 0, 8'h00, 0, 1, mk(0, 0, 0, 0, 0, 0));
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, mk(0, 0, 0, 0, 0, 0));
        applyStimulus(0, 0, 0, 0, 8'h55, 0, 1, mk(0, 0, 0, 0, 0, 0));

        // Set A = 1..8, commit at address 7
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 1, 3'(i), 8'(i + 1), 8'h00, 0, 1, mk(0, 0, 0, 0, i == 7, 0));
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, mk(1, 3, 5, 6, 1, 0));
        applyStimulus(0, 0, 0, 0, 8'h55, 0, 1, mk(2, 4, 7, 8, 1, 0));

        // Set B = 0x10..0x17 loaded while reading A; commit cycle still reads A
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                applyStimulus(0, 1, 3'(i), 8'(8'h10 + i), 8'h00, 0, 1, mk(1, 3, 5, 6, 1, 0));
            else
                applyStimulus(0, 1, 3'(i), 8'(8'h10 + i), 8'h55, 0, 1, mk(2, 4, 7, 8, 1, 0));
        end
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, mk(8'h10, 8'h12, 8'h14, 8'h15, 1, 0));
        applyStimulus(0, 0, 0, 0, 8'h55, 0, 1, mk(8'h11, 8'h13, 8'h16, 8'h17, 1, 0));
        applyStimulus(0, 0, 0, 0, 8'hAA, 0, 1, mk(0, 0, 0, 0, 1, 0));
        applyStimulus(0, 0, 0, 0, 8'hFF, 0, 1, mk(0, 0, 0, 0, 1, 0));

        // Incomplete set (address 6 skipped): error, no swap, sticky
        for (int i = 0; i < 6; i++)
            applyStimulus(0, 1, 3'(i), 8'(8'h20 + i), 8'h00, 0, 1, mk(8'h10, 8'h12, 8'h14, 8'h15, 1, 0));
        applyStimulus(0, 1, 3'd7, 8'h27, 8'h00, 0, 1, mk(8'h10, 8'h12, 8'h14, 8'h15, 1, 1));
        applyStimulus(0, 0, 0, 0, 8'h55, 0, 1, mk(8'h11, 8'h13, 8'h16, 8'h17, 1, 1));

        // Set C with 0x80 at w0 and w1 rewritten (last write wins)
        applyStimulus(0, 1, 3'd0, 8'h80, 8'h00, 0, 1, mk(8'h10, 8'h12, 8'h14, 8'h15, 1, 1));
        applyStimulus(0, 1, 3'd1, 8'h55, 8'h00, 0, 1, mk(8'h10, 8'h12, 8'h14, 8'h15, 1, 1));
        for (int i = 1; i < 8; i++)
            applyStimulus(0, 1, 3'(i), 8'(8'h20 + i), 8'h00, 0, 1, mk(8'h10, 8'h12, 8'h14, 8'h15, 1, 1));
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, mk(8'h80, 8'h22, 8'h24, 8'h25, 1, 1));
        applyStimulus(0, 0, 0, 0, 8'h11, 0, 1, mk(8'h80, 8'h23, 8'h24, 8'h27, 1, 1));
        applyStimulus(0, 0, 0, 0, 8'h55, 0, 1, mk(8'h21, 8'h23, 8'h26, 8'h27, 1, 1));

        // Reset mid-load, with a colliding commit write that must be ignored
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 3'(i), 8'(i + 1), 8'h00, 0, 1, mk(8'h80, 8'h22, 8'h24, 8'h25, 1, 1));
        applyStimulus(1, 1, 3'd7, 8'h99, 8'h00, 0, 1, mk(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 1, 3'(i), 8'(i + 1), 8'h00, 0, 1, mk(0, 0, 0, 0, i == 7, 0));
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, mk(1, 3, 5, 6, 1, 0));
        applyStimulus(0, 0, 0, 0, 8'h04, 0, 1, mk(1, 3, 7, 6, 1, 0));
`ifdef OPERAND_TRANSPOSE_EN
        applyStimulus(0, 0, 0, 0, 8'h04, 1, 1, mk(1, 3, 6, 7, 1, 0));
        applyStimulus(0, 0, 0, 0, 8'h55, 1, 1, mk(2, 4, 6, 8, 1, 0));
        applyStimulus(0, 0, 0, 0, 8'h04, 0, 1, mk(1, 3, 7, 6, 1, 0));
`endif

        // Drain the scoreboard with a bounded wait
        applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, mk(0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 10 && expQ.size() != 0; k++) @(negedge clk);
        if (expQ.size() != 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL drain: %0d expected entries left, want 0", expQ.size());
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/operand_buffer.md
OPERAND_BUFFER -- requirements
Module: operand_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand byte width; only 8 is required to be supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 load_en  input  1  write strobe for data_in at mem_addr.
REQ-005 mem_addr  input  3  byte address; 0-3 = weights w0..w3, 4-7 = inputs x0..x3.
REQ-006 data_in  input  DATA_W  signed operand byte being loaded.
REQ-007 a0_sel, a1_sel, b0_sel, b1_sel  input  2 each  operand selects from the control unit.
REQ-008 a0, a1, b0, b1  output  DATA_W each  signed registered operands to the systolic array.
REQ-009 bank_valid  output  1  read bank holds a committed, complete operand set.
REQ-010 load_err  output  1  sticky flag: a commit was attempted with an incomplete set.

Function
REQ-011 SHALL hold two 8-byte banks: a write bank (load target) and a read bank (operand source).
REQ-012 load_en=1: data_in written to write-bank byte mem_addr at the clock edge; the matching bit of an 8-bit written-mask is set.
REQ-013 load_en=1 with mem_addr=7 is a commit: if the mask, including this write, is all ones, banks swap at that edge, mask clears, bank_valid goes 1.
REQ-014 Commit with incomplete mask: no swap; mask clears; load_err set; bank_valid unchanged.
REQ-015 Rewriting a byte before commit overwrites it; last write wins; no error.
REQ-016 Operand mux (untransposed): a0: sel 0->w0, 1->w1; a1: 0->w2, 1->w3; b0: 0->x0, 1->x2; b1: 0->x1, 1->x3; sel 2 or 3 -> 0 on every port.
REQ-017 Operands SHALL be registered: value for sels presented in cycle N appears on outputs in cycle N+1; latency exactly 1.
REQ-018 Read bank contents SHALL be used for operands; while bank_valid=0 all operands read 0 regardless of sel.
REQ-019 Commit and operand read in the same cycle: the registered operand reflects the pre-swap read bank; new bank is visible from the next cycle's sels.
REQ-020 Writes never alter the read bank; loading of the next set fully overlaps computation on the current set.
REQ-021 mem_addr wrap 7->0 requires no special handling; address 0 after a commit begins a new set.

Reset
REQ-022 rst=1 SHALL clear both banks, written-mask, a0/a1/b0/b1 (0), bank_valid (0), load_err (0), and the bank pointer to bank 0 as write bank.
REQ-023 rst has priority over load_en in the same cycle; a partial set in progress is discarded.
REQ-024 First cycle after rst deasserts SHALL accept a write normally.

Configuration
REQ-025 Macro OPERAND_TRANSPOSE_EN: when defined, input port transpose (1 bit) is added and, when transpose=1, b0 maps 0->x0, 1->x1 and b1 maps 0->x2, 1->x3; transpose=0 uses REQ-016.
REQ-026 Without OPERAND_TRANSPOSE_EN: no transpose port; REQ-016 mapping fixed.
REQ-027 transpose SHALL be sampled with the sels (same 1-cycle latency).

Verification
REQ-028 Reset, then sels all 0 -> a0=a1=b0=b1=0, bank_valid=0, load_err=0.
REQ-029 Load addr 0..7 with 1,2,3,4,5,6,7,8 -> bank_valid=1 after addr-7 edge; sels (0,0,0,0) -> next cycle a0=1,a1=3,b0=5,b1=6; sels (1,1,1,1) -> a0=2,a1=4,b0=7,b1=8.
REQ-030 Load addrs 0..5 then 7 (skip 6) -> load_err=1, no swap, previous operands unchanged; stays 1 until rst.
REQ-031 With set A committed, load set B (values 0x10..0x17) while cycling sels -> operands stay from A until B's addr-7 commit, then reflect B next cycle; same-cycle commit+read returns A.
REQ-032 Sel 2 on all ports with valid bank -> all operands 0; data_in=0x80 at w0, sel a0=0 -> a0=0x80 (-128).
REQ-033 OPERAND_TRANSPOSE_EN defined, set 1..8 committed, transpose=1, b0_sel=1, b1_sel=0 -> b0=6, b1=7; rst mid-load (after addr 3) -> bank_valid=0, all outputs 0.
